// File: rtl/hiscore_pkg.sv
// Shared definitions between the hiscore ioctl host and its NVRAM consumer.
// Holds the transfer indices and the host sequencer state encoding.
package hiscore_pkg;

    localparam logic [7:0] INDEX_CONFIG = 8'd3;
    localparam logic [7:0] INDEX_DUMP   = 8'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DL_OPEN,
        ST_DL_WAIT,
        ST_DL_WR,
        ST_DL_GAP,
        ST_UL_OPEN,
        ST_UL_SETTLE,
        ST_UL_OUT,
        ST_CLOSE
    } host_state_t;

endpackage

// File: rtl/hiscore_ioctl_timer.sv
// Load/decrement/zero counter for the write-gap and upload-settle phases.
// Zero flag is combinational from the count; a load takes effect on the next edge.
module hiscore_ioctl_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hiscore_ioctl_host.sv
// Host side of the hiscore ioctl port: streams bytes into ioctl_wr strobes or walks ioctl_addr back out.
// Download 1 byte / (2+WR_GAP) cycles, upload 1 byte / (UL_SETTLE+1); stalls on s_valid low or m_ready low.
module hiscore_ioctl_host
    import hiscore_pkg::*;
#(
    parameter int ADDR_WIDTH = 25,
    parameter int WR_GAP     = 3,
    parameter int UL_SETTLE  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_upload,
    input  logic [7:0]            cmd_index,
    input  logic [ADDR_WIDTH-1:0] cmd_length,
    input  logic                  abort,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  ioctl_download,
    output logic                  ioctl_upload,
    output logic                  ioctl_wr,
    output logic [ADDR_WIDTH-1:0] ioctl_addr,
    output logic [7:0]            ioctl_dout,
    output logic [7:0]            ioctl_index,
    input  logic [7:0]            ioctl_din,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    localparam int TMAX = (WR_GAP > UL_SETTLE) ? WR_GAP : UL_SETTLE;
    localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
    localparam logic [TW-1:0] GAP_LOAD    = TW'((WR_GAP > 0) ? WR_GAP - 1 : 0);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'((UL_SETTLE > 0) ? UL_SETTLE - 1 : 0);

    host_state_t           state;
    host_state_t           state_nxt;
    logic                  ready_q;
    logic                  aborted_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic                  len_zero;
    logic                  last_byte;

    logic                  accept;
    logic                  dl_take;
    logic                  ul_take;
    logic                  addr_inc;
    logic                  abort_close;
    logic                  tmr_load;
    logic [TW-1:0]         tmr_val;
    logic                  tmr_zero;

    assign len_zero  = (len_q == '0);
    assign last_byte = (ioctl_addr == (len_q - ADDR_WIDTH'(1)));

    hiscore_ioctl_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        dl_take     = 1'b0;
        ul_take     = 1'b0;
        addr_inc    = 1'b0;
        abort_close = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    accept    = 1'b1;
                    state_nxt = cmd_upload ? ST_UL_OPEN : ST_DL_OPEN;
                end
            end
            ST_DL_OPEN: begin
                if (len_zero) begin
                    state_nxt = ST_CLOSE;
                end else if (abort) begin
                    state_nxt   = ST_CLOSE;
                    abort_close = 1'b1;
                end else begin
                    state_nxt = ST_DL_WAIT;
                end
            end
            ST_DL_WAIT: begin
                if (abort) begin
                    state_nxt   = ST_CLOSE;
                    abort_close = 1'b1;
                end else if (s_valid) begin
                    dl_take   = 1'b1;
                    state_nxt = ST_DL_WR;
                end
            end
            ST_DL_WR: begin
                // The strobe is already on the pins this cycle, so a late abort only skips what follows.
                if (last_byte) begin
                    state_nxt = ST_CLOSE;
                end else if (abort) begin
                    state_nxt   = ST_CLOSE;
                    abort_close = 1'b1;
                end else if (WR_GAP == 0) begin
                    addr_inc  = 1'b1;
                    state_nxt = ST_DL_WAIT;
                end else begin
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LOAD;
                    state_nxt = ST_DL_GAP;
                end
            end
            ST_DL_GAP: begin
                if (abort) begin
                    state_nxt   = ST_CLOSE;
                    abort_close = 1'b1;
                end else if (tmr_zero) begin
                    addr_inc  = 1'b1;
                    state_nxt = ST_DL_WAIT;
                end
            end
            ST_UL_OPEN: begin
                if (len_zero) begin
                    state_nxt = ST_CLOSE;
                end else if (abort) begin
                    state_nxt   = ST_CLOSE;
                    abort_close = 1'b1;
                end else begin
                    tmr_load  = 1'b1;
                    tmr_val   = SETTLE_LOAD;
                    state_nxt = ST_UL_SETTLE;
                end
            end
            ST_UL_SETTLE: begin
                if (abort) begin
                    state_nxt   = ST_CLOSE;
                    abort_close = 1'b1;
                end else if (tmr_zero) begin
                    ul_take   = 1'b1;
                    state_nxt = ST_UL_OUT;
                end
            end
            ST_UL_OUT: begin
                // A completing final handshake wins over a simultaneous abort.
                if (m_ready && last_byte) begin
                    state_nxt = ST_CLOSE;
                end else if (abort) begin
                    state_nxt   = ST_CLOSE;
                    abort_close = 1'b1;
                end else if (m_ready) begin
                    addr_inc  = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = SETTLE_LOAD;
                    state_nxt = ST_UL_SETTLE;
                end
            end
            ST_CLOSE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ioctl_index is only reloaded on accept so the consumer can still read it after the window falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            aborted_q   <= 1'b0;
            len_q       <= '0;
            ioctl_index <= '0;
            ioctl_addr  <= '0;
            ioctl_dout  <= '0;
            m_data      <= '0;
        end else begin
            ready_q   <= (state_nxt == ST_IDLE);
            aborted_q <= abort_close;
            if (accept) begin
                len_q       <= cmd_length;
                ioctl_index <= cmd_index;
                ioctl_addr  <= '0;
            end else if (addr_inc) begin
                ioctl_addr <= ioctl_addr + ADDR_WIDTH'(1);
            end
            if (dl_take) begin
                ioctl_dout <= s_data;
            end
            if (ul_take) begin
                m_data <= ioctl_din;
            end
        end
    end

    assign cmd_ready      = ready_q;
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_CLOSE);
    assign aborted        = aborted_q;
    assign ioctl_wr       = (state == ST_DL_WR);
    assign ioctl_download = (state == ST_DL_OPEN) || (state == ST_DL_WAIT) ||
                            (state == ST_DL_WR)   || (state == ST_DL_GAP);
    assign ioctl_upload   = (state == ST_UL_OPEN) || (state == ST_UL_SETTLE) || (state == ST_UL_OUT);
    assign s_ready        = (state == ST_DL_WAIT) && !abort;
    assign m_valid        = (state == ST_UL_OUT);

    assert property (@(posedge clk) disable iff (!reset_n) !(ioctl_download && ioctl_upload));
    assert property (@(posedge clk) disable iff (!reset_n) ioctl_wr |-> ioctl_download);

endmodule

// File: tb/tb_hiscore_ioctl_host.sv
// Bench for hiscore_ioctl_host: directed transfers plus random ones against a transaction-level model.
module tb_hiscore_ioctl_host;
    import hiscore_pkg::*;

    localparam int AW        = 25;
    localparam int WR_GAP    = 3;
    localparam int UL_SETTLE = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_upload = 1'b0;
    logic [7:0]    cmd_index = 8'h00;
    logic [AW-1:0] cmd_length = '0;
    logic          abort = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          ioctl_download;
    logic          ioctl_upload;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic [7:0]    ioctl_index;
    logic [7:0]    ioctl_din = 8'h00;
    logic          busy;
    logic          done;
    logic          aborted;

    always #5 clk = ~clk;

    hiscore_ioctl_host #(
        .ADDR_WIDTH (AW),
        .WR_GAP     (WR_GAP),
        .UL_SETTLE  (UL_SETTLE)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_upload     (cmd_upload),
        .cmd_index      (cmd_index),
        .cmd_length     (cmd_length),
        .abort          (abort),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .ioctl_download (ioctl_download),
        .ioctl_upload   (ioctl_upload),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_din      (ioctl_din),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted)
    );

    // Consumer memory with a two-cycle read latency.
    logic [7:0] mem [0:255];
    logic [7:0] din_p1 = 8'h00;
    always @(posedge clk) begin
        din_p1    <= mem[ioctl_addr[7:0]];
        ioctl_din <= din_p1;
    end

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         mon_on = 1'b0;
    bit         model_busy = 1'b0;
    bit         model_up = 1'b0;
    logic [7:0] exp_index = 8'h00;
    logic [7:0] dl_q[$];
    logic [7:0] src_bytes[$];
    int         src_gaps[$];
    int         wr_cnt = 0;
    int         ul_cnt = 0;
    int         done_cnt = 0;
    int         busy_cyc = 0;
    int         win_cyc = 0;
    int         last_wr_cyc = 0;
    bit         last_aborted = 1'b0;
    bit         exact_gap = 1'b0;
    bit         s_took = 1'b0;
    bit         acc_seen = 1'b0;
    bit         mv_seen = 1'b0;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of the DUT pins against the transaction model.
    task automatic monitor();
        s_took   = 1'b0;
        acc_seen = 1'b0;
        mv_seen  = m_valid;
        if (mon_on) begin
            chk_eq("busy", busy, model_busy);
            chk_eq("cmd_ready", cmd_ready, !model_busy);
            chk_eq("ioctl_index", ioctl_index, exp_index);
            chk_eq("wr_outside_window", ioctl_wr && !ioctl_download, 0);
            chk_eq("done_while_idle", done && !model_busy, 0);
            if (model_busy && !done) begin
                chk_eq("download_window", ioctl_download, !model_up);
                chk_eq("upload_window", ioctl_upload, model_up);
            end else begin
                chk_eq("download_closed", ioctl_download, 0);
                chk_eq("upload_closed", ioctl_upload, 0);
            end
            chk_eq("s_ready_context", s_ready && !(model_busy && !model_up), 0);
            chk_eq("m_valid_context", m_valid && !(model_busy && model_up), 0);
            if (busy) busy_cyc++;
            if (ioctl_download || ioctl_upload) win_cyc++;
            if (ioctl_wr) begin
                chk_eq("wr_addr", ioctl_addr, wr_cnt);
                if (wr_cnt < dl_q.size()) chk_eq("wr_dout", ioctl_dout, dl_q[wr_cnt]);
                else chk_eq("wr_without_byte", wr_cnt, dl_q.size());
                if (wr_cnt > 0) begin
                    if (exact_gap) chk_eq("wr_spacing", cyc - last_wr_cyc, 2 + WR_GAP);
                    else chk_eq("wr_spacing_min", (cyc - last_wr_cyc) >= 2 + WR_GAP, 1);
                end
                last_wr_cyc = cyc;
                wr_cnt++;
            end
            if (s_valid && s_ready) begin
                dl_q.push_back(s_data);
                s_took = 1'b1;
            end
            if (m_valid) begin
                chk_eq("m_data", m_data, mem[ul_cnt]);
                chk_eq("ul_addr", ioctl_addr, ul_cnt);
                if (m_ready) ul_cnt++;
            end
            if (done) begin
                done_cnt++;
                last_aborted = aborted;
                model_busy   = 1'b0;
            end else begin
                chk_eq("aborted_without_done", aborted, 0);
            end
            if (cmd_valid && cmd_ready) begin
                model_busy = 1'b1;
                model_up   = cmd_upload;
                exp_index  = cmd_index;
                wr_cnt     = 0;
                ul_cnt     = 0;
                busy_cyc   = 0;
                win_cyc    = 0;
                dl_q.delete();
                acc_seen   = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        chk_eq(name, {cmd_ready, s_ready, m_valid, m_data, ioctl_download, ioctl_upload, ioctl_wr,
                      ioctl_addr, ioctl_dout, ioctl_index, busy, done, aborted}, 0);
    endtask

    task automatic release_reset();
        mon_on     = 1'b0;
        model_busy = 1'b0;
        exp_index  = 8'h00;
        cmd_valid  = 1'b0;
        s_valid    = 1'b0;
        abort      = 1'b0;
        m_ready    = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
    endtask

    task automatic send_cmd(input bit up, input logic [7:0] idx, input int len);
        int t;
        cmd_valid  = 1'b1;
        cmd_upload = up;
        cmd_index  = idx;
        cmd_length = AW'(len);
        t = 0;
        do begin
            tick();
            t++;
        end while (!acc_seen && t < 50);
        chk_eq("cmd_accept_timeout", acc_seen, 1);
        cmd_valid = 1'b0;
        cmd_index = 8'($urandom);
    endtask

    task automatic run_xfer(input bit up, input logic [7:0] idx, input int len,
                            input int abort_at, input int stall_at, input bit noise);
        int d0;
        int bi;
        int gap_left;
        int stall_left;
        int t;
        int n_exp;
        bit fired;
        bit exp_abort;
        exact_gap = 1'b1;
        foreach (src_gaps[i]) if (src_gaps[i] != 0) exact_gap = 1'b0;
        send_cmd(up, idx, len);
        d0         = done_cnt;
        bi         = 0;
        gap_left   = (src_gaps.size() > 0) ? src_gaps[0] : 0;
        stall_left = 10;
        fired      = 1'b0;
        t          = 0;
        while (done_cnt == d0 && t < 4000) begin
            s_valid = !up && (bi < len) && (gap_left == 0);
            s_data  = (bi < src_bytes.size()) ? src_bytes[bi] : 8'h00;
            m_ready = !(stall_at >= 0 && ul_cnt == stall_at && stall_left > 0);
            abort   = 1'b0;
            if (abort_at >= 0 && !fired && (up ? ul_cnt : wr_cnt) == abort_at) begin
                abort = 1'b1;
                fired = 1'b1;
            end
            cmd_valid  = noise && ($urandom_range(0, 3) == 0);
            cmd_upload = 1'($urandom);
            tick();
            t++;
            if (s_took) begin
                bi++;
                gap_left = (bi < src_gaps.size()) ? src_gaps[bi] : 0;
            end else if (!s_valid && gap_left > 0) begin
                gap_left--;
            end
            if (!m_ready && mv_seen) stall_left--;
        end
        abort     = 1'b0;
        s_valid   = 1'b0;
        m_ready   = 1'b1;
        cmd_valid = 1'b0;
        chk_eq("done_timeout", done_cnt, d0 + 1);
        exp_abort = (abort_at >= 0) && (abort_at < len);
        n_exp     = exp_abort ? abort_at : len;
        chk_eq("aborted_flag", last_aborted, exp_abort);
        if (up) begin
            chk_eq("ul_bytes", ul_cnt, n_exp);
            chk_eq("wr_during_upload", wr_cnt, 0);
        end else begin
            chk_eq("wr_count", wr_cnt, n_exp);
            chk_eq("m_valid_during_download", ul_cnt, 0);
        end
        repeat (3) tick();
        chk_eq("done_once", done_cnt, d0 + 1);
    endtask

    initial begin
        int len;
        int ab;
        int st;
        bit up;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5c);
        #1;
        check_outputs_zero("outputs_in_reset");
        release_reset();
        tick();
        chk_eq("cmd_ready_after_release", cmd_ready, 1);

        // Config download, stream always valid.
        src_bytes = '{8'h00, 8'h00, 8'h43, 8'h0b, 8'h0f, 8'h10, 8'h01, 8'h00};
        src_gaps.delete();
        run_xfer(1'b0, INDEX_CONFIG, 8, -1, -1, 1'b0);
        chk_eq("t1_busy_cycles", busy_cyc, 39);
        chk_eq("t1_window_cycles", win_cyc, 38);
        chk_eq("t1_index_held", ioctl_index, 8'h03);
        chk_eq("t1_last_dout", ioctl_dout, 8'h00);

        // Dump download with gaps in the byte stream.
        src_bytes = '{8'h5a, 8'ha5, 8'h3c, 8'hc3};
        src_gaps  = '{0, 0, 7, 2};
        run_xfer(1'b0, INDEX_DUMP, 4, -1, -1, 1'b0);
        chk_eq("t2_last_addr", ioctl_addr, 3);
        chk_eq("t2_last_dout", ioctl_dout, 8'hc3);

        // Uploads: free-running sink, then a stalled sink on the second byte.
        mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
        src_gaps.delete();
        run_xfer(1'b1, INDEX_DUMP, 4, -1, -1, 1'b0);
        chk_eq("t3_busy_cycles", busy_cyc, 22);
        chk_eq("t3_last_m_data", m_data, 8'hDD);
        run_xfer(1'b1, INDEX_DUMP, 4, -1, 1, 1'b0);
        chk_eq("t4_busy_cycles", busy_cyc, 32);

        // Zero-length transfers, then abort after the third strobe.
        run_xfer(1'b0, INDEX_CONFIG, 0, -1, -1, 1'b0);
        chk_eq("t5_dl_busy", busy_cyc, 2);
        chk_eq("t5_dl_window", win_cyc, 1);
        run_xfer(1'b1, INDEX_DUMP, 0, -1, -1, 1'b0);
        chk_eq("t5_ul_busy", busy_cyc, 2);
        chk_eq("t5_ul_window", win_cyc, 1);
        src_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_xfer(1'b0, INDEX_CONFIG, 8, 3, -1, 1'b0);
        chk_eq("t5_abort_dout", ioctl_dout, 8'h33);

        // Abort while idle must be ignored.
        abort = 1'b1;
        repeat (3) tick();
        abort = 1'b0;
        chk_eq("idle_abort_busy", busy, 0);

        // Asynchronous reset in the middle of a download.
        exact_gap = 1'b1;
        send_cmd(1'b0, INDEX_CONFIG, 8);
        s_valid = 1'b1;
        s_data  = 8'h99;
        for (int t = 0; t < 200 && wr_cnt < 2; t++) tick();
        chk_eq("pre_reset_window", ioctl_download, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("outputs_async_reset");
        release_reset();
        tick();
        chk_eq("cmd_ready_after_rereset", cmd_ready, 1);
        src_bytes = '{8'hde, 8'had, 8'hbe};
        src_gaps.delete();
        run_xfer(1'b0, INDEX_DUMP, 3, -1, -1, 1'b0);

        // Random transfers with random aborts, stalls and commands offered while busy.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 16; n++) begin
            up  = 1'($urandom);
            len = $urandom_range(0, 12);
            src_bytes.delete();
            src_gaps.delete();
            for (int i = 0; i < len; i++) begin
                src_bytes.push_back(8'($urandom));
                src_gaps.push_back($urandom_range(0, 5));
            end
            ab = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            st = (up && ab < 0 && len > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            run_xfer(up, ($urandom_range(0, 1) == 1) ? INDEX_DUMP : INDEX_CONFIG, len, ab, st, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
